tick_divider: RTL and testbench

- Parametrised, single-clock-domain successor to the game's fixed 10 Hz / 1 Hz clock divider.
- Produces one-cycle enable pulses (base_tick, slow_tick) instead of derived clocks, so all consumers stay on CLOCK_50M.
- The slow divisor is a runtime input; the game FSM uses it to set gravity / drop rate per level.
- Optional square-wave outputs drive LEDs and blinkers.

---
 rtl/tick_divider_if.sv | 24 ++
 rtl/tick_divider.sv | 101 ++++++++++
 tb/tb_tick_divider.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/tick_divider_if.sv
// Control and tick bundle for tick_divider: the consumer (master) drives the
// count controls, the divider (slave) returns the enable pulses and counter.
interface tick_divider_if #(
    parameter int DIV_W = 8
);
    logic             enable;
    logic             restart;
    logic [DIV_W-1:0] divisor;
    logic             base_tick;
    logic             slow_tick;
    logic             base_sq;
    logic             slow_sq;
    logic [DIV_W-1:0] slow_count;

    modport master (
        output enable, restart, divisor,
        input  base_tick, slow_tick, base_sq, slow_sq, slow_count
    );

    modport slave (
        input  enable, restart, divisor,
        output base_tick, slow_tick, base_sq, slow_sq, slow_count
    );
endinterface

// File: rtl/tick_divider.sv
// Prescaler plus runtime slow divider producing one-cycle enable pulses on CLOCK_50M.
// Define TICK_SQ_EN to build the base_sq/slow_sq toggle outputs; otherwise they read 0.
module tick_divider #(
    parameter int CLK_HZ  = 50000000,
    parameter int BASE_HZ = 10,
    parameter int DIV_W   = 8
) (
    input  logic           CLOCK_50M,
    input  logic           RESET_N,
    tick_divider_if.slave  tif
);
    localparam int PRE   = CLK_HZ / BASE_HZ;
    localparam int PRE_W = (PRE > 1) ? $clog2(PRE) : 1;

    generate
        if ((CLK_HZ % BASE_HZ) != 0 || PRE < 2) begin : g_bad_cfg
            $error("tick_divider: CLK_HZ must be a multiple of BASE_HZ with CLK_HZ/BASE_HZ >= 2");
        end
    endgenerate

    logic [PRE_W-1:0] pre_cnt, pre_nxt;
    logic [DIV_W-1:0] slow_cnt, slow_nxt;
    logic [DIV_W-1:0] div_eff;
    logic             counted;
    logic             base_ev;
    logic             slow_hit;
    logic             base_tick_q, slow_tick_q;

    // Compare with >= so a divisor shrunk below the running count fires at once.
    always_comb begin
        counted  = tif.enable & ~tif.restart;
        base_ev  = 1'b0;
        slow_hit = 1'b0;
        pre_nxt  = pre_cnt;
        slow_nxt = slow_cnt;
        div_eff  = (tif.divisor == '0) ? DIV_W'(1) : tif.divisor;
        if (counted) begin
            if (pre_cnt == PRE_W'(PRE - 1)) begin
                pre_nxt = '0;
                base_ev = 1'b1;
            end else begin
                pre_nxt = pre_cnt + 1'b1;
            end
        end
        if (base_ev) begin
            if (slow_cnt >= div_eff - DIV_W'(1)) begin
                slow_nxt = '0;
                slow_hit = 1'b1;
            end else begin
                slow_nxt = slow_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_cnt     <= '0;
            slow_cnt    <= '0;
            base_tick_q <= 1'b0;
            slow_tick_q <= 1'b0;
        end else if (tif.restart) begin
            pre_cnt     <= '0;
            slow_cnt    <= '0;
            base_tick_q <= 1'b0;
            slow_tick_q <= 1'b0;
        end else begin
            pre_cnt     <= pre_nxt;
            slow_cnt    <= slow_nxt;
            base_tick_q <= base_ev;
            slow_tick_q <= slow_hit;
        end
    end

    assign tif.base_tick  = base_tick_q;
    assign tif.slow_tick  = slow_tick_q;
    assign tif.slow_count = slow_cnt;

`ifdef TICK_SQ_EN
    logic base_sq_q, slow_sq_q;

    always_ff @(posedge CLOCK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            base_sq_q <= 1'b0;
            slow_sq_q <= 1'b0;
        end else if (tif.restart) begin
            base_sq_q <= 1'b0;
            slow_sq_q <= 1'b0;
        end else begin
            if (base_ev)  base_sq_q <= ~base_sq_q;
            if (slow_hit) slow_sq_q <= ~slow_sq_q;
        end
    end

    assign tif.base_sq = base_sq_q;
    assign tif.slow_sq = slow_sq_q;
`else
    assign tif.base_sq = 1'b0;
    assign tif.slow_sq = 1'b0;
`endif

endmodule

// File: tb/tb_tick_divider.sv
// Bench for tick_divider at CLK_HZ=100, BASE_HZ=10 (PRE=10), DIV_W=4.
module tb_tick_divider;
    localparam int DIV_W = 4;

    logic CLOCK_50M = 1'b0;
    logic RESET_N   = 1'b0;

    tick_divider_if #(.DIV_W(DIV_W)) tif ();

    tick_divider #(.CLK_HZ(100), .BASE_HZ(10), .DIV_W(DIV_W)) dut (
        .CLOCK_50M (CLOCK_50M),
        .RESET_N   (RESET_N),
        .tif       (tif.slave)
    );

    always #5 CLOCK_50M = ~CLOCK_50M;

    typedef struct {
        logic       enable;
        logic [3:0] divisor;
        int         cycles;
        int         exp_base;
        int         exp_slow;
        int         exp_count;
        int         exp_bsq;
        int         exp_ssq;
    } vec_t;

    vec_t vecs[9];
    vec_t sb[$];

    int checks = 0;
    int failures = 0;
    int cnt_base = 0, cnt_slow = 0, long_cnt = 0;
    logic prev_b = 1'b0, prev_s = 1'b0;

    function automatic int sqx(input int v);
`ifdef TICK_SQ_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50M);
            #1;
            cnt_base += int'(tif.base_tick);
            cnt_slow += int'(tif.slow_tick);
            if ((tif.base_tick && prev_b) || (tif.slow_tick && prev_s)) long_cnt++;
            prev_b = tif.base_tick;
            prev_s = tif.slow_tick;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_base_tick"}, int'(tif.base_tick), 0);
        chk({tag, "_slow_tick"}, int'(tif.slow_tick), 0);
        chk({tag, "_base_sq"},   int'(tif.base_sq), 0);
        chk({tag, "_slow_sq"},   int'(tif.slow_sq), 0);
        chk({tag, "_slow_count"}, int'(tif.slow_count), 0);
    endtask

    // Expects RESET_N low and the time just after a clock edge.
    task automatic run_scen1(input string tag);
        tif.enable  = 1'b1;
        tif.restart = 1'b0;
        tif.divisor = 4'd3;
        RESET_N     = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            step(1);
            chk({tag, "_base_tick"}, int'(tif.base_tick), (e % 10 == 0) ? 1 : 0);
            chk({tag, "_slow_tick"}, int'(tif.slow_tick), (e % 30 == 0) ? 1 : 0);
            chk({tag, "_slow_count"}, int'(tif.slow_count), (e / 10) % 3);
            chk({tag, "_base_sq"}, int'(tif.base_sq), sqx((e / 10) % 2));
            chk({tag, "_slow_sq"}, int'(tif.slow_sq), sqx((e / 30) % 2));
        end
    endtask

    task automatic do_restart();
        tif.restart = 1'b1;
        step(1);
        tif.restart = 1'b0;
        cnt_base = 0;
        cnt_slow = 0;
    endtask

    initial begin
        // en, div, cycles, base, slow, count, bsq, ssq -- all from a restarted state
        vecs[0] = '{1'b1, 4'd0,  100, 10, 10, 0,  0, 0};
        vecs[1] = '{1'b1, 4'd1,  55,  5,  5,  0,  1, 1};
        vecs[2] = '{1'b1, 4'd3,  75,  7,  2,  1,  1, 0};
        vecs[3] = '{1'b1, 4'd4,  100, 10, 2,  2,  0, 0};
        vecs[4] = '{1'b1, 4'd15, 100, 10, 0,  10, 0, 0};
        vecs[5] = '{1'b0, 4'd3,  40,  0,  0,  0,  0, 0};
        vecs[6] = '{1'b1, 4'd2,  9,   0,  0,  0,  0, 0};
        vecs[7] = '{1'b1, 4'd2,  10,  1,  0,  1,  1, 0};
        vecs[8] = '{1'b1, 4'd2,  20,  2,  1,  0,  0, 1};

        tif.enable  = 1'b0;
        tif.restart = 1'b0;
        tif.divisor = 4'd0;

        // Reset state, then the basic divisor=3 sequence
        step(3);
        chk_all_zero("reset");
        run_scen1("s1");

        // Table: each vector from a fresh restart, scoreboarded
        foreach (vecs[i]) begin
            do_restart();
            tif.enable  = vecs[i].enable;
            tif.divisor = vecs[i].divisor;
            sb.push_back(vecs[i]);
            step(vecs[i].cycles);
            begin
                vec_t v;
                v = sb.pop_front();
                chk($sformatf("vec%0d_base_cnt", i), cnt_base, v.exp_base);
                chk($sformatf("vec%0d_slow_cnt", i), cnt_slow, v.exp_slow);
                chk($sformatf("vec%0d_slow_count", i), int'(tif.slow_count), v.exp_count);
                chk($sformatf("vec%0d_base_sq", i), int'(tif.base_sq), sqx(v.exp_bsq));
                chk($sformatf("vec%0d_slow_sq", i), int'(tif.slow_sq), sqx(v.exp_ssq));
            end
        end
        chk("sb_empty", sb.size(), 0);

        // Divisor shrinks below the running count
        tif.enable = 1'b1; tif.divisor = 4'd5;
        do_restart();
        step(30);
        chk("s3_count3", int'(tif.slow_count), 3);
        tif.divisor = 4'd2;
        step(9);
        chk("s3_no_slow_early", cnt_slow, 0);
        step(1);
        chk("s3_base_now", int'(tif.base_tick), 1);
        chk("s3_slow_now", int'(tif.slow_tick), 1);
        chk("s3_count0", int'(tif.slow_count), 0);
        step(10);
        chk("s3_slow_skip", int'(tif.slow_tick), 0);
        chk("s3_count1", int'(tif.slow_count), 1);
        step(10);
        chk("s3_slow_next", int'(tif.slow_tick), 1);
        chk("s3_count_wrap", int'(tif.slow_count), 0);

        // Enable low for 7 cycles at pre_cnt=4
        tif.divisor = 4'd3;
        do_restart();
        step(14);
        chk("s4_bsq_before", int'(tif.base_sq), sqx(1));
        tif.enable = 1'b0;
        cnt_base = 0;
        step(7);
        chk("s4_no_ticks", cnt_base, 0);
        chk("s4_bsq_hold", int'(tif.base_sq), sqx(1));
        chk("s4_count_hold", int'(tif.slow_count), 1);
        tif.enable = 1'b1;
        step(5);
        chk("s4_not_yet", cnt_base, 0);
        step(1);
        chk("s4_delayed_tick", int'(tif.base_tick), 1);
        chk("s4_bsq_toggle", int'(tif.base_sq), sqx(0));

        // Restart at pre_cnt=6, slow_count=2
        do_restart();
        step(56);
        chk("s5_count_pre", int'(tif.slow_count), 2);
        chk("s5_bsq_pre", int'(tif.base_sq), sqx(1));
        chk("s5_ssq_pre", int'(tif.slow_sq), sqx(1));
        do_restart();
        chk_all_zero("s5_restart");
        step(9);
        chk("s5_quiet", cnt_base, 0);
        step(1);
        chk("s5_first_tick", int'(tif.base_tick), 1);

        // Asynchronous reset mid-run, then the basic sequence again
        step(23);
        #3;
        RESET_N = 1'b0;
        #1;
        chk_all_zero("s6_async");
        prev_b = 1'b0;
        prev_s = 1'b0;
        step(1);
        run_scen1("s6");

        chk("pulse_width", long_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
